// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sound_pkg
// Description : Shared audio types and helpers for the sound subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

    localparam int SD_W = 10;

    typedef logic [SD_W-1:0] mix_t;

    // Clip a 12-bit mix sum to the modulator's 10-bit full scale.
    function automatic mix_t sat_mix(input logic [11:0] v);
        if (v > 12'd1023) begin
            return '1;
        end
        return v[SD_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_mod1.sv
`default_nettype none
// ============================================================================
// Module      : sd_mod1
// Description : First-order sigma-delta modulator, one 10-bit mix in, 1 bit out.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_mod1
    import sound_pkg::*;
(
    input  logic       clk28,
    input  logic       rst,
    input  mix_t       mix,
    output logic       dac
);

    mix_t          acc_q;
    mix_t          acc_d;
    logic          dac_q;
    logic          dac_d;
    logic [SD_W:0] s;

    // The carry out of the accumulator is the output bit; density is mix/1024.
    always_comb begin
        s     = {1'b0, acc_q} + {1'b0, mix};
        acc_d = s[SD_W-1:0];
        dac_d = s[SD_W];
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            acc_q <= mix_t'(10'h200);
            dac_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end

    assign dac = dac_q;

endmodule
`default_nettype wire

// File: rtl/sound_sd_dac.sv
`default_nettype none
// ============================================================================
// Module      : sound_sd_dac
// Description : Stereo Covox/beeper/tape mixer feeding two sigma-delta DACs.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_sd_dac
    import sound_pkg::*;
#(
    parameter int PRESCALE   = 28,
    parameter int BEEPER_LVL = 128,
    parameter int TAPE_LVL   = 32
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] ch_l0,
    input  logic [7:0] ch_l1,
    input  logic [7:0] ch_r0,
    input  logic [7:0] ch_r1,
    input  logic       beeper,
    input  logic       tape_out,
    output logic       dac_l,
    output logic       dac_r
);

    localparam logic [7:0]  PCNT_MAX  = 8'(PRESCALE - 1);
    localparam logic [11:0] BEEP_ADD  = 12'(BEEPER_LVL);
    localparam logic [11:0] TAPE_ADD  = 12'(TAPE_LVL);
    localparam mix_t        MIX_RESET = mix_t'(10'd256);

    logic [7:0]  pcnt_q;
    logic [7:0]  pcnt_d;
    logic        strobe;
    logic [11:0] extra;
    logic [11:0] sum_l;
    logic [11:0] sum_r;
    mix_t        mix_l_q;
    mix_t        mix_l_d;
    mix_t        mix_r_q;
    mix_t        mix_r_d;

    always_comb begin
        strobe = (pcnt_q == PCNT_MAX);
        pcnt_d = strobe ? 8'd0 : pcnt_q + 8'd1;
    end

    always_comb begin
        extra   = (beeper ? BEEP_ADD : 12'd0) + (tape_out ? TAPE_ADD : 12'd0);
        sum_l   = 12'(ch_l0) + 12'(ch_l1) + extra;
        sum_r   = 12'(ch_r0) + 12'(ch_r1) + extra;
        mix_l_d = mix_l_q;
        mix_r_d = mix_r_q;
        // Inputs are only looked at in the strobe cycle; mute takes effect there too.
        if (strobe) begin
            mix_l_d = en ? sat_mix(sum_l) : '0;
            mix_r_d = en ? sat_mix(sum_r) : '0;
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            pcnt_q  <= 8'd0;
            mix_l_q <= MIX_RESET;
            mix_r_q <= MIX_RESET;
        end else begin
            pcnt_q  <= pcnt_d;
            mix_l_q <= mix_l_d;
            mix_r_q <= mix_r_d;
        end
    end

    sd_mod1 u_mod_l (
        .clk28 (clk28),
        .rst   (rst),
        .mix   (mix_l_q),
        .dac   (dac_l)
    );

    sd_mod1 u_mod_r (
        .clk28 (clk28),
        .rst   (rst),
        .mix   (mix_r_q),
        .dac   (dac_r)
    );

endmodule
`default_nettype wire

// File: tb/tb_sound_sd_dac.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_sd_dac
// Description : Self-checking bench for sound_sd_dac (density and timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_sd_dac;

    localparam int PRESCALE = 28;
    localparam int BL       = 128;
    localparam int TL       = 32;
    localparam int BL_SAT   = 600;

    logic       clk28 = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic [7:0] ch_l0 = 8'h80;
    logic [7:0] ch_l1 = 8'h80;
    logic [7:0] ch_r0 = 8'h80;
    logic [7:0] ch_r1 = 8'h80;
    logic       beeper   = 1'b0;
    logic       tape_out = 1'b0;
    logic       dac_l, dac_r, sat_l, sat_r;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk28 = ~clk28;

    sound_sd_dac #(.PRESCALE(PRESCALE), .BEEPER_LVL(BL), .TAPE_LVL(TL)) dut (
        .clk28(clk28), .rst(rst), .en(en),
        .ch_l0(ch_l0), .ch_l1(ch_l1), .ch_r0(ch_r0), .ch_r1(ch_r1),
        .beeper(beeper), .tape_out(tape_out), .dac_l(dac_l), .dac_r(dac_r)
    );

    sound_sd_dac #(.PRESCALE(PRESCALE), .BEEPER_LVL(BL_SAT), .TAPE_LVL(TL)) dut_sat (
        .clk28(clk28), .rst(rst), .en(en),
        .ch_l0(ch_l0), .ch_l1(ch_l1), .ch_r0(ch_r0), .ch_r1(ch_r1),
        .beeper(beeper), .tape_out(tape_out), .dac_l(sat_l), .dac_r(sat_r)
    );

    // Reference: the mix a side should settle to, straight from the mixing rule.
    function automatic int model_mix(int a, int b, int bp, int tp, int e, int bl);
        int s;
        if (e == 0) return 0;
        s = a + b + (bp != 0 ? bl : 0) + (tp != 0 ? TL : 0);
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic tick();
        @(negedge clk28);
    endtask

    // Advance to the negedge where strobe is high; false if it never comes.
    task automatic find_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * PRESCALE; i++) begin
            if (dut.strobe === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic settle();
        bit ok;
        tick();
        find_strobe(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL strobe_timeout: no strobe seen within %0d cycles", 4 * PRESCALE);
        end
        repeat (3) tick();
    endtask

    task automatic count_ones(input int n, output int l, output int r,
                              output int sl, output int sr);
        l = 0; r = 0; sl = 0; sr = 0;
        for (int i = 0; i < n; i++) begin
            l  += int'(dac_l);
            r  += int'(dac_r);
            sl += int'(sat_l);
            sr += int'(sat_r);
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (dac_l !== 1'b0 || dac_r !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dac: got l=%b r=%b, want 0 0", dac_l, dac_r);
        end
        vectors++;
        if (dut.pcnt_q !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_pcnt: got %0d, want 0", dut.pcnt_q);
        end
        vectors++;
        if (dut.mix_l_q !== 10'd256 || dut.mix_r_q !== 10'd256) begin
            miscompares++;
            $display("FAIL reset_mix: got %0d/%0d, want 256/256", dut.mix_l_q, dut.mix_r_q);
        end
        rst = 1'b0;
        n = 0;
        while (dut.strobe !== 1'b1 && n < 4 * PRESCALE) begin
            tick();
            n++;
        end
        vectors++;
        if (n != PRESCALE - 1) begin
            miscompares++;
            $display("FAIL first_strobe: got %0d cycles, want %0d", n, PRESCALE - 1);
        end
    endtask

    task automatic check_density(input string name, input int want_l, input int want_r);
        int l, r, sl, sr;
        settle();
        count_ones(1024, l, r, sl, sr);
        vectors++;
        if (l != want_l || r != want_r) begin
            miscompares++;
            $display("FAIL %s: ones l=%0d r=%0d, want l=%0d r=%0d", name, l, r, want_l, want_r);
        end
    endtask

    task automatic test_midscale();
        en = 1'b1;
        ch_l0 = 8'h80; ch_l1 = 8'h80; ch_r0 = 8'h80; ch_r1 = 8'h80;
        beeper = 1'b0; tape_out = 1'b0;
        check_density("midscale", 256, 256);
    endtask

    task automatic test_saturation();
        int l, r, sl, sr, wsat, wmain;
        ch_l0 = 8'hFF; ch_l1 = 8'hFF; ch_r0 = 8'hFF; ch_r1 = 8'hFF;
        beeper = 1'b1; tape_out = 1'b0;
        wsat  = model_mix(255, 255, 1, 0, 1, BL_SAT);
        wmain = model_mix(255, 255, 1, 0, 1, BL);
        settle();
        count_ones(1024, l, r, sl, sr);
        vectors++;
        if (sl != wsat || sr != wsat) begin
            miscompares++;
            $display("FAIL saturation: ones l=%0d r=%0d, want %0d", sl, sr, wsat);
        end
        vectors++;
        if (l != wmain || r != wmain) begin
            miscompares++;
            $display("FAIL full_unclipped: ones l=%0d r=%0d, want %0d", l, r, wmain);
        end
        beeper = 1'b0;
    endtask

    task automatic test_stereo();
        ch_l0 = 8'h00; ch_l1 = 8'h00; ch_r0 = 8'hFF; ch_r1 = 8'hFF;
        beeper = 1'b0; tape_out = 1'b0;
        check_density("stereo", 0, 510);
    endtask

    task automatic test_latch_timing();
        bit ok;
        int bad;
        ch_l0 = 8'h80; ch_l1 = 8'h80; ch_r0 = 8'h80; ch_r1 = 8'h80;
        settle();
        find_strobe(ok);
        tick();
        ch_l0 = 8'hFF;
        bad = 0;
        while (dut.strobe !== 1'b1 && bad < 4 * PRESCALE) begin
            vectors++;
            if (dut.mix_l_q !== 10'd256) begin
                miscompares++;
                $display("FAIL latch_hold: mix_l=%0d, want 256", dut.mix_l_q);
            end
            tick();
            bad++;
        end
        tick();
        vectors++;
        if (dut.mix_l_q !== 10'(model_mix(255, 128, 0, 0, 1, BL))) begin
            miscompares++;
            $display("FAIL latch_update: mix_l=%0d, want %0d", dut.mix_l_q,
                     model_mix(255, 128, 0, 0, 1, BL));
        end
    endtask

    task automatic test_mute();
        int ones;
        ch_l0 = 8'hC0; ch_l1 = 8'hC0; ch_r0 = 8'hC0; ch_r1 = 8'hC0;
        check_density("pre_mute", 384, 384);
        en = 1'b0;
        repeat (PRESCALE + 2) tick();
        ones = 0;
        for (int i = 0; i < 300; i++) begin
            ones += int'(dac_l) + int'(dac_r);
            tick();
        end
        vectors++;
        if (ones != 0) begin
            miscompares++;
            $display("FAIL mute: %0d ones after mute, want 0", ones);
        end
        en = 1'b1;
        check_density("unmute", 384, 384);
    endtask

    task automatic test_random();
        int a, b, c, d, bp, tp, wl, wr;
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(255); b = $urandom_range(255);
            c = $urandom_range(255); d = $urandom_range(255);
            bp = $urandom_range(1);  tp = $urandom_range(1);
            ch_l0 = 8'(a); ch_l1 = 8'(b); ch_r0 = 8'(c); ch_r1 = 8'(d);
            beeper = bp[0]; tape_out = tp[0];
            wl = model_mix(a, b, bp, tp, 1, BL);
            wr = model_mix(c, d, bp, tp, 1, BL);
            check_density("random", wl, wr);
        end
        beeper = 1'b0; tape_out = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Reset in the middle of a sample must restart the prescaler cleanly.
        repeat (7) tick();
        test_reset();
        check_density("post_reset", model_mix(int'(ch_l0), int'(ch_l1), 0, 0, 1, BL),
                      model_mix(int'(ch_r0), int'(ch_r1), 0, 0, 1, BL));
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_saturation();
        test_stereo();
        test_latch_timing();
        test_mute();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
